// File: rtl/seg_frame_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seg_frame_reader
// Function : Rebuilds BCD digits from a multiplexed active-low 7-seg bus and
//            emits one frame per full scan over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module seg_frame_reader #(
    parameter int DIGITS        = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     dig_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovr
);

    localparam int              c_CW       = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(STABLE_CYCLES - 1);
    localparam logic [0:0]      c_COUNT    = 1'b0;
    localparam logic [0:0]      c_HELD     = 1'b1;

    // Returns {blank, err, bcd}; segment order {a..g}, 0 = lit
    function automatic logic [5:0] f_decode(input logic [6:0] seg);
        logic [5:0] v;
        case (seg)
            7'b0000001: v = 6'b00_0000;
            7'b1001111: v = 6'b00_0001;
            7'b0010010: v = 6'b00_0010;
            7'b0000110: v = 6'b00_0011;
            7'b1001100: v = 6'b00_0100;
            7'b0100100: v = 6'b00_0101;
            7'b0100000: v = 6'b00_0110;
            7'b0001111: v = 6'b00_0111;
            7'b0000000: v = 6'b00_1000;
            7'b0000100: v = 6'b00_1001;
            7'b1111111: v = 6'b10_1111;
            default:    v = 6'b01_1110;
        endcase
        return v;
    endfunction

    logic [DIGITS+6:0]    r_sample;
    logic [c_CW-1:0]      r_cnt;
    logic [0:0]           r_state;
    logic [4*DIGITS-1:0]  r_wbcd;
    logic [DIGITS-1:0]    r_wblank;
    logic [DIGITS-1:0]    r_werr;
    logic [DIGITS-1:0]    r_seen;

    logic                 w_eq;
    logic                 w_onehot;
    logic                 w_cap;
    logic [5:0]           w_dec;
    logic [4*DIGITS-1:0]  w_nbcd;
    logic [DIGITS-1:0]    w_nblank;
    logic [DIGITS-1:0]    w_nerr;
    logic [DIGITS-1:0]    w_seen_nxt;
    logic                 w_done;
    logic                 w_xfer;

    assign w_eq       = ({dig_sel, seg_in} == r_sample);
    assign w_onehot   = $onehot(dig_sel);
    assign w_cap      = w_eq && (r_state == c_COUNT) && w_onehot && (r_cnt == c_CNT_LAST);
    assign w_dec      = f_decode(seg_in);
    assign w_seen_nxt = r_seen | (w_cap ? dig_sel : '0);
    assign w_done     = w_cap && (&w_seen_nxt);
    assign w_xfer     = out_valid && out_ready;

    // Working slots including the capture happening this cycle, so a
    // completing frame can be published on the same edge.
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_slot
            assign w_nbcd[4*i +: 4] = (w_cap && dig_sel[i]) ? w_dec[3:0] : r_wbcd[4*i +: 4];
            assign w_nblank[i]      = (w_cap && dig_sel[i]) ? w_dec[5]   : r_wblank[i];
            assign w_nerr[i]        = (w_cap && dig_sel[i]) ? w_dec[4]   : r_werr[i];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= {{DIGITS{1'b0}}, 7'h7F};
            r_cnt    <= '0;
            r_state  <= c_COUNT;
        end else begin
            r_sample <= {dig_sel, seg_in};
            if (!w_eq) begin
                r_cnt   <= '0;
                r_state <= c_COUNT;
            end else if (r_state == c_COUNT) begin
                if (!w_onehot) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_cnt   <= '0;
                    r_state <= c_HELD;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbcd    <= '0;
            r_wblank  <= '0;
            r_werr    <= '0;
            r_seen    <= '0;
            bcd_out   <= '0;
            blank_out <= '0;
            err_out   <= '0;
            out_valid <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            r_wbcd   <= w_nbcd;
            r_wblank <= w_nblank;
            r_werr   <= w_nerr;
            r_seen   <= w_done ? '0 : w_seen_nxt;
            if (w_done) begin
                if (!out_valid || out_ready) begin
                    bcd_out   <= w_nbcd;
                    blank_out <= w_nblank;
                    err_out   <= w_nerr;
                    out_valid <= 1'b1;
                    if (w_xfer) ovr <= 1'b0;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (w_xfer) begin
                out_valid <= 1'b0;
                ovr       <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_frame_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seg_frame_reader
// Function : Scoreboard bench for seg_frame_reader (DIGITS=2, STABLE_CYCLES=4).
// Revision : 1.0
// ============================================================================
module tb_seg_frame_reader;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                           S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000,
                           S9 = 7'b0000100, SBLK = 7'b1111111, SBAD = 7'b1110000;

    typedef struct packed {
        logic [7:0] bcd;
        logic [1:0] blank;
        logic [1:0] err;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h7F;
    logic [1:0] dig_sel = 2'b00;
    logic [7:0] bcd_out;
    logic [1:0] blank_out;
    logic [1:0] err_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       ovr;

    int n_vec = 0;
    int n_err = 0;
    frame_t exp_q[$];
    frame_t obs_q[$];

    always #5 clk = ~clk;

    seg_frame_reader #(.DIGITS(2), .STABLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_sel(dig_sel),
        .bcd_out(bcd_out), .blank_out(blank_out), .err_out(err_out),
        .out_valid(out_valid), .out_ready(out_ready), .ovr(ovr)
    );

    // Frames accepted by the consumer on the coming edge
    always @(negedge clk)
        if (rst_n && out_valid && out_ready)
            obs_q.push_back({bcd_out, blank_out, err_out});

    task automatic drive(input logic [1:0] sel, input logic [6:0] seg, input int n);
        repeat (n) begin
            dig_sel = sel;
            seg_in  = seg;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        dig_sel = 2'b00;
        seg_in  = 7'h7F;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        dig_sel   = 2'b01;
        seg_in    = S8;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bcd_out, blank_out, err_out, out_valid, ovr} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", {bcd_out, blank_out, err_out, out_valid, ovr});
        end
        rst_n = 1'b1;
        drive(2'b01, S8, 5);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_one_digit_no_frame: out_valid got %b required 0", out_valid);
        end
        drive(2'b10, S1, 5);
        exp_q.push_back({8'h18, 2'b00, 2'b00});
        n_vec++;
        if (out_valid !== 1'b1 || bcd_out !== 8'h18) begin
            n_err++;
            $display("FAIL reset_first_frame: valid/bcd got %b/%h required 1/18", out_valid, bcd_out);
        end
        drive(2'b10, S1, 2);
    endtask

    task automatic test_scan();
        do_reset();
        out_ready = 1'b1;
        drive(2'b01, S5, 5);
        drive(2'b10, S3, 4);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL scan_early: out_valid got %b required 0 before E4", out_valid);
        end
        drive(2'b10, S3, 1);
        exp_q.push_back({8'h35, 2'b00, 2'b00});
        n_vec++;
        if (out_valid !== 1'b1 || {bcd_out, blank_out, err_out} !== 12'h350) begin
            n_err++;
            $display("FAIL scan_frame: valid/frame got %b/%h required 1/350", out_valid, {bcd_out, blank_out, err_out});
        end
        drive(2'b10, S3, 1);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL scan_one_cycle: out_valid got %b required 0", out_valid);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        out_ready = 1'b1;
        drive(2'b01, S5, 3);
        drive(2'b10, S3, 5);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_no_capture: out_valid got %b required 0", out_valid);
        end
        drive(2'b01, S1, 5);
        exp_q.push_back({8'h31, 2'b00, 2'b00});
        n_vec++;
        if (out_valid !== 1'b1 || bcd_out !== 8'h31) begin
            n_err++;
            $display("FAIL glitch_recapture: valid/bcd got %b/%h required 1/31", out_valid, bcd_out);
        end
        drive(2'b01, S1, 2);
    endtask

    task automatic test_blank_err();
        do_reset();
        out_ready = 1'b1;
        drive(2'b01, SBAD, 5);
        drive(2'b10, SBLK, 5);
        exp_q.push_back({8'hFE, 2'b10, 2'b01});
        n_vec++;
        if (out_valid !== 1'b1 || bcd_out !== 8'hFE || blank_out !== 2'b10 || err_out !== 2'b01) begin
            n_err++;
            $display("FAIL blank_err: valid/bcd/blank/err got %b/%h/%b/%b required 1/fe/10/01",
                     out_valid, bcd_out, blank_out, err_out);
        end
        drive(2'b10, SBLK, 2);
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        drive(2'b01, S2, 5);
        drive(2'b10, S4, 5);
        n_vec++;
        if (out_valid !== 1'b1 || bcd_out !== 8'h42 || ovr !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_first: valid/bcd/ovr got %b/%h/%b required 1/42/0", out_valid, bcd_out, ovr);
        end
        drive(2'b01, S9, 5);
        drive(2'b10, S6, 5);
        n_vec++;
        if (out_valid !== 1'b1 || bcd_out !== 8'h42 || ovr !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_drop: valid/bcd/ovr got %b/%h/%b required 1/42/1", out_valid, bcd_out, ovr);
        end
        out_ready = 1'b1;
        exp_q.push_back({8'h42, 2'b00, 2'b00});
        drive(2'b10, S6, 1);
        n_vec++;
        if (out_valid !== 1'b0 || ovr !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_clear: valid/ovr got %b/%b required 0/0", out_valid, ovr);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        drive(2'b01, S7, 5);
        drive(2'b10, S2, 5);
        drive(2'b01, S4, 5);
        drive(2'b10, S9, 4);
        out_ready = 1'b1;
        exp_q.push_back({8'h27, 2'b00, 2'b00});
        drive(2'b10, S9, 1);
        exp_q.push_back({8'h94, 2'b00, 2'b00});
        n_vec++;
        if (out_valid !== 1'b1 || bcd_out !== 8'h94 || ovr !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_load: valid/bcd/ovr got %b/%h/%b required 1/94/0", out_valid, bcd_out, ovr);
        end
        drive(2'b10, S9, 1);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain: out_valid got %b required 0", out_valid);
        end
    endtask

    task automatic test_bad_sel_and_reset();
        do_reset();
        out_ready = 1'b1;
        drive(2'b11, S5, 10);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sel_multi: out_valid got %b required 0", out_valid);
        end
        drive(2'b00, S5, 10);
        drive(2'b10, S6, 5);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL sel_zero: out_valid got %b required 0", out_valid);
        end
        // digit 1 is now seen; reset mid-count of digit 0 must forget it
        drive(2'b01, S3, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b01, S3, 5);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_clears_seen: out_valid got %b required 0", out_valid);
        end
        drive(2'b10, S8, 5);
        exp_q.push_back({8'h83, 2'b00, 2'b00});
        n_vec++;
        if (out_valid !== 1'b1 || bcd_out !== 8'h83) begin
            n_err++;
            $display("FAIL reset_new_frame: valid/bcd got %b/%h required 1/83", out_valid, bcd_out);
        end
        drive(2'b10, S8, 2);
        out_ready = 1'b0;
        drive(2'b01, S0, 5);
        drive(2'b10, S0, 5);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || bcd_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_drops_valid: valid/bcd got %b/%h required 0/00", out_valid, bcd_out);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
    endtask

    task automatic test_scoreboard();
        frame_t e;
        frame_t o;
        n_vec++;
        if (obs_q.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL sb_count: observed %0d frames required %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL sb_frame: got %h required %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_glitch();
        test_blank_err();
        test_overflow();
        test_back_to_back();
        test_bad_sel_and_reset();
        repeat (2) @(posedge clk);
        #1;
        test_scoreboard();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_frame_reader.md
# seg_frame_reader

Sequential seven-segment reader. It samples a multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit select) and rebuilds the BCD digits driven on it. Each digit pattern must be stable for a minimum number of cycles before it is captured. The reader then assembles one frame per full display scan and hands it to a consumer over a valid/ready handshake. It is the display-side counterpart of the BCD-to-segment decoders and is used for self-checking display paths (tens/units).

## Interface
- DIGITS, 2, number of multiplexed digits (digit 0 = units, 1 = tens, ...)
- STABLE_CYCLES, 4, consecutive equal samples required before capture (≥1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- seg_in  in  7  segment lines {a,b,c,d,e,f,g}, 0 = lit
- dig_sel  in  DIGITS  digit select, one-hot, active-high
- bcd_out  out  4*DIGITS  captured digits, digit i at [4i+3:4i]
- blank_out  out  DIGITS  digit i was blank (all segments off)
- err_out  out  DIGITS  digit i held an undecodable pattern
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts frame
- ovr  out  1  at least one frame dropped since last transfer

## Operation
- Decode (a..g, 0 = lit): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- 1111111 decodes to blank: slot = 4'hF, blank bit set.
- Any other pattern decodes to slot = 4'hE with the err bit set.
- Input stage: {dig_sel, seg_in} registered every cycle into a sample register.
- Stability tracker FSM, states COUNT and HELD:
  - COUNT: each edge where the input equals the sample register, cnt++.
  - Input differs from the sample register: cnt←0 and the FSM stays in or returns to COUNT.
  - cnt reaching STABLE_CYCLES-1 with an equal input: capture, then go to HELD.
  - HELD: no further captures. The first differing input sends the FSM to COUNT with cnt←0.
  - A sample whose dig_sel is not one-hot (zero or multiple bits) never captures, and cnt is held at 0.
- Capture writes the decoded value, blank bit and err bit into working slot i (the one-hot index) and sets seen[i].
- Recapturing a digit before the frame completes overwrites its slot.
- Frame complete: the capture makes seen all-ones. On that same edge:
  - If out_valid=0, or out_valid&out_ready: working slots → bcd_out/blank_out/err_out, out_valid←1, seen←0.
  - Otherwise: frame dropped, outputs unchanged, ovr←1, seen←0.
- Transfer: an edge with out_valid&out_ready and no new frame clears out_valid. Any transfer clears ovr, unless a drop occurs on the same edge, which is impossible by the rules above.
- Outputs are stable while out_valid=1 and out_ready=0.

## Timing
- Reset (async assert, sync-free release) values:
  - bcd_out=0, blank_out=0, err_out=0, out_valid=0, ovr=0.
  - seen=0, cnt=0, FSM=COUNT.
  - Sample register = {0, 7'b1111111}.
- Latency: a pair first captured into the sample register at edge E0 and held through edge E_STABLE_CYCLES is captured at E_STABLE_CYCLES.
- For STABLE_CYCLES=1, capture happens at E1.
- out_valid rises on the same edge as the last-digit capture. There is no extra pipeline stage.
- Frame-complete and transfer on the same edge: the new frame loads and out_valid stays 1 (back-to-back).
- Reset mid-frame discards seen and the working slots. Reset mid-handshake drops out_valid immediately.
- Throughput: one frame per DIGITS×(STABLE_CYCLES+1) cycles minimum.

## Test plan
- Reset with seg_in=0000000, dig_sel=01 held: all outputs 0 during reset. After release, slot 0 captures at E4 (STABLE_CYCLES=4), and out_valid stays 0 until digit 1 is seen.
- Scan dig_sel=01/seg=0100100 for 5 cycles, then 10/seg=0000110 for 5 cycles, with out_ready=1: out_valid rises at E4 of the second digit, bcd_out=8'h35, blank_out=0, err_out=0, one cycle wide.
- Digit 0 held only 3 cycles (glitch), then a different pattern: no capture and seen stays 0. Then hold 1001111 for 5 cycles: slot 0 = 1.
- Digit 1 = 1111111, digit 0 = 1110000: bcd_out=8'hFE, blank_out=2'b10, err_out=2'b01.
- out_ready=0 and two full frames scanned: first frame is held unchanged, ovr=1 after the second. Raise out_ready for 1 cycle: out_valid→0, ovr→0.
- dig_sel=11 or 00 held 10 cycles with a valid pattern: no capture. Assert rst_n=0 mid-count: seen cleared, and the next frame requires all digits again.
